cla_addsub_pipe: RTL

Parametrised, pipelined carry-lookahead adder/subtractor built from GROUP-bit lookahead groups with ripple between groups. It is the successor to the fixed 16-bit registered CLA adder in the fp16 datapath. It adds runtime add/subtract mode, carry/borrow-in, signed overflow, configurable carry-chain pipelining and a valid/ready handshake with backpressure. It feeds mantissa add/align paths in the fp16 adder and multiplier.

---
 rtl/cla_addsub_pipe.sv | 136 +++++++++++++
 1 files changed

// File: rtl/cla_addsub_pipe.sv
// Pipelined carry-lookahead adder/subtractor with valid/ready handshake.
// Groups of GROUP bits use lookahead carries; groups ripple; slices are pipelined.
module cla_addsub_pipe #(
  parameter int WIDTH  = 16,
  parameter int GROUP  = 4,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int SW = WIDTH / STAGES;
  localparam int NG = SW / GROUP;

  // Returns {carry into slice MSB, carry out of slice, slice sum}.
  function automatic logic [SW+1:0] cla_slice(
    input logic [SW-1:0] x,
    input logic [SW-1:0] y,
    input logic          ci
  );
    logic [SW-1:0] g;
    logic [SW-1:0] p;
    logic [SW-1:0] s;
    logic [SW:0]   c;
    logic          t;
    logic          pp;
    g    = x & y;
    p    = x ^ y;
    c    = '0;
    c[0] = ci;
    for (int gi = 0; gi < NG; gi++) begin
      for (int i = 0; i < GROUP; i++) begin
        t  = g[gi*GROUP+i];
        pp = p[gi*GROUP+i];
        for (int j = i - 1; j >= 0; j--) begin
          t  = t | (pp & g[gi*GROUP+j]);
          pp = pp & p[gi*GROUP+j];
        end
        c[gi*GROUP+i+1] = t | (pp & c[gi*GROUP]);
      end
    end
    s = p ^ c[SW-1:0];
    return {c[SW-1], c[SW], s};
  endfunction

  logic             adv;
  logic [WIDTH-1:0] a_q [STAGES];
  logic [WIDTH-1:0] b_q [STAGES];
  logic [WIDTH-1:0] s_q [STAGES];
  logic [WIDTH-1:0] a_d [STAGES];
  logic [WIDTH-1:0] b_d [STAGES];
  logic [WIDTH-1:0] s_d [STAGES];
  logic [STAGES-1:0] v_q;
  logic [STAGES-1:0] v_d;
  logic [STAGES-1:0] c_q;
  logic [STAGES-1:0] c_d;
  logic             ovf_q;
  logic             ovf_d;

  logic [WIDTH-1:0]  ai [STAGES];
  logic [WIDTH-1:0]  bi [STAGES];
  logic [WIDTH-1:0]  si [STAGES];
  logic [STAGES-1:0] vi;
  logic [STAGES-1:0] ci;
  logic [SW+1:0]     r  [STAGES];

  assign adv      = !v_q[STAGES-1] | out_ready;
  assign in_ready = adv;

  // Stage inputs: operand transform for stage 0, previous registers otherwise;
  // each stage then resolves its own slice and forwards the rest.
  always_comb begin
    ai[0] = a;
    bi[0] = sub ? ~b : b;
    ci[0] = sub ? ~cin : cin;
    vi[0] = in_valid;
    si[0] = '0;
    for (int k = 1; k < STAGES; k++) begin
      ai[k] = a_q[k-1];
      bi[k] = b_q[k-1];
      ci[k] = c_q[k-1];
      vi[k] = v_q[k-1];
      si[k] = s_q[k-1];
    end
    for (int k = 0; k < STAGES; k++) begin
      r[k]   = cla_slice(ai[k][k*SW +: SW], bi[k][k*SW +: SW], ci[k]);
      a_d[k] = ai[k];
      b_d[k] = bi[k];
      v_d[k] = vi[k];
      s_d[k] = si[k];
      s_d[k][k*SW +: SW] = r[k][SW-1:0];
      c_d[k] = r[k][SW];
    end
    ovf_d = r[STAGES-1][SW+1] ^ r[STAGES-1][SW];
  end

  // Pipeline registers: clear on reset, shift together when output can move.
  always_ff @(posedge clk) begin
    if (rst) begin
      v_q   <= '0;
      c_q   <= '0;
      ovf_q <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
      end
    end else if (adv) begin
      v_q   <= v_d;
      c_q   <= c_d;
      ovf_q <= ovf_d;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= a_d[k];
        b_q[k] <= b_d[k];
        s_q[k] <= s_d[k];
      end
    end
  end

  assign out_valid = v_q[STAGES-1];
  assign sum       = s_q[STAGES-1];
  assign cout      = c_q[STAGES-1];
  assign ovf       = ovf_q;

endmodule
